// File: rtl/ram8_sweep_pkg.sv
// ram8_pkg: shared types and constants for the ram8_sweep block.
//   word_t  - 16-bit data word
//   addr_t  - 3-bit entry index
//   DEPTH   - number of storage entries (fixed at 8)
//   state_t - sweep controller state {IDLE, CLEAR}
package ram8_pkg;

   localparam int WORD_W = 16;
   localparam int ADDR_W = 3;
   localparam int DEPTH  = 8;

   typedef logic [WORD_W-1:0] word_t;
   typedef logic [ADDR_W-1:0] addr_t;

   typedef enum logic {
      IDLE  = 1'b0,
      CLEAR = 1'b1
   } state_t;

endpackage : ram8_pkg

// File: rtl/ram8_sweep_if.sv
// ram8_sweep_if: access bus of the ram8_sweep register file.
//   in        - write data
//   address   - read/write entry select
//   load      - write request
//   clr_req   - start a clear sweep (level-sampled)
//   out       - combinational read data of entry[address]
//   busy      - clear sweep in progress
//   load_drop - one-cycle pulse, a load was refused during a sweep
// Modports: master drives requests, slave (the RAM) drives responses.
interface ram8_sweep_if #(
   parameter int WIDTH = 16
);
   import ram8_pkg::*;

   logic [WIDTH-1:0] in;
   addr_t            address;
   logic             load;
   logic             clr_req;
   logic [WIDTH-1:0] out;
   logic             busy;
   logic             load_drop;

   modport master (
      output in, address, load, clr_req,
      input  out, busy, load_drop
   );

   modport slave (
      input  in, address, load, clr_req,
      output out, busy, load_drop
   );

endinterface : ram8_sweep_if

// File: rtl/ram8_sweep_mux.sv
// Mux8way16: 8-way word multiplexer used as the ram8_sweep read path.
//   a..h - candidate words, selected by sel = 0..7
//   sel  - select
//   out  - selected word (purely combinational)
module Mux8way16 #(
   parameter int WIDTH = 16
) (
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   input  logic [WIDTH-1:0] c,
   input  logic [WIDTH-1:0] d,
   input  logic [WIDTH-1:0] e,
   input  logic [WIDTH-1:0] f,
   input  logic [WIDTH-1:0] g,
   input  logic [WIDTH-1:0] h,
   input  logic [2:0]       sel,
   output logic [WIDTH-1:0] out
);

   always_comb begin
      // NOTE: out gets a value on every path (default first) so no latch is inferred.
      out = a;
      case (sel)
         3'd1:    out = b;
         3'd2:    out = c;
         3'd3:    out = d;
         3'd4:    out = e;
         3'd5:    out = f;
         3'd6:    out = g;
         3'd7:    out = h;
         default: out = a;
      endcase
   end

endmodule : Mux8way16

// File: rtl/ram8_sweep.sv
// ram8_sweep: 8-entry register file with a self-timed clear sweep.
//   clk   - rising-edge clock
//   rst_n - asynchronous active-low reset (clears all entries)
//   bus   - ram8_sweep_if.slave: in/address/load/clr_req requests,
//           out/busy/load_drop responses
// In IDLE a load writes entry[address]; clr_req starts an 8-cycle sweep that
// zeroes one entry per cycle (index 0 first). Loads during the sweep are
// refused and flagged on load_drop the following cycle; clr_req is ignored.
// Configuration: define RAM8_SWEEP_BYPASS_EN to forward in to out in the
// same cycle as an accepted load (write-through read).
module ram8_sweep #(
   parameter int WIDTH = 16,
   parameter int DEPTH = 8
) (
   input  logic         clk,
   input  logic         rst_n,
   ram8_sweep_if.slave  bus
);
   import ram8_pkg::*;

   logic [WIDTH-1:0] entry [DEPTH];
   logic [WIDTH-1:0] mux_out;
   state_t           state;
   addr_t            idx;
   logic             busy_q;
   logic             drop_q;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         // NOTE: entries are plain flops, not a RAM macro, so resetting them is legal and cheap.
         for (int i = 0; i < DEPTH; i++) entry[i] <= '0;
         state  <= IDLE;
         idx    <= '0;
         busy_q <= 1'b0;
         drop_q <= 1'b0;
      end else begin
         // NOTE: non-blocking assignments so every register samples pre-edge values.
         drop_q <= 1'b0;
         case (state)
            IDLE: begin
               if (bus.load) entry[bus.address] <= bus.in;
               // The write above and the sweep start may happen on the same edge.
               if (bus.clr_req) begin
                  state  <= CLEAR;
                  idx    <= '0;
                  busy_q <= 1'b1;
               end
            end
            CLEAR: begin
               entry[idx] <= '0;
               // 3-bit increment: wraps 7 -> 0 exactly on the exit edge.
               idx <= idx + addr_t'(1);
               if (idx == addr_t'(DEPTH - 1)) begin
                  state  <= IDLE;
                  busy_q <= 1'b0;
               end
               if (bus.load) drop_q <= 1'b1;
            end
            default: state <= IDLE;
         endcase
      end
   end

   Mux8way16 #(
      .WIDTH (WIDTH)
   ) u_read_mux (
      .a   (entry[0]),
      .b   (entry[1]),
      .c   (entry[2]),
      .d   (entry[3]),
      .e   (entry[4]),
      .f   (entry[5]),
      .g   (entry[6]),
      .h   (entry[7]),
      .sel (bus.address),
      .out (mux_out)
   );

   always_comb begin
      bus.out = mux_out;
`ifdef RAM8_SWEEP_BYPASS_EN
      // Only accepted loads forward; a load refused during the sweep never does.
      if (state == IDLE && bus.load) bus.out = bus.in;
`endif
   end

   assign bus.busy      = busy_q;
   assign bus.load_drop = drop_q;

endmodule : ram8_sweep
